// File: rtl/score_pkg.sv
// Shared types and helpers for the BCD score counter: digit type, add/sub mode
// and the nibble clamp used on every externally supplied BCD value.
package score_pkg;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } bcd_op_e;

  function automatic bcd_digit_t clamp_digit(input logic [3:0] v);
    return (v > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : v;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the score ripple chain: adds or subtracts an operand (0-9)
// plus a carry/borrow, producing the next digit and carry/borrow out.
module bcd_digit_cell
  import score_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  bcd_op_e    op_i,
  input  bcd_digit_t operand_i,
  input  logic       cin_i,
  output bcd_digit_t digit_o,
  output logic       cout_o
);

  logic [4:0] sum;
  logic [4:0] diff;

  // NOTE: combinational blocks use blocking '=' so later statements see the
  // values computed earlier in the same evaluation.
  always_comb begin
    sum  = {1'b0, digit_i} + {1'b0, operand_i} + {4'b0000, cin_i};
    diff = {1'b0, digit_i} - {1'b0, operand_i} - {4'b0000, cin_i};
    // NOTE: every output gets a default before the branches so no path can
    // leave it unassigned and infer a latch.
    digit_o = digit_i;
    cout_o  = 1'b0;
    if (op_i == OP_ADD) begin
      if (sum > 5'd9) begin
        digit_o = sum[3:0] - 4'd10;
        cout_o  = 1'b1;
      end else begin
        digit_o = sum[3:0];
      end
    end else begin
      if (diff[4]) begin
        // Range is -10..-1 here; adding ten modulo 16 restores the digit.
        digit_o = diff[3:0] + 4'd10;
        cout_o  = 1'b1;
      end else begin
        digit_o = diff[3:0];
      end
    end
  end

endmodule

// File: rtl/bcd_score_counter.sv
// N-digit BCD score register with multi-point add/penalty per cycle, zero floor,
// saturate-or-wrap at the top, and a session high-score tracker.
module bcd_score_counter
  import score_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter bit SATURATE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                add_en,
  input  logic [3:0]          add_amt,
  input  logic                sub_en,
  input  logic [3:0]          sub_amt,
  input  logic                pb_clear_op,
  input  logic [4*DIGITS-1:0] init_value,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] high_score,
  output logic                ovf,
  output logic                udf,
  output logic                new_high
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{BCD_MAX_DIGIT}};

  logic [W-1:0] score_q, score_d;
  logic [W-1:0] high_q, high_d;
  logic         ovf_q, ovf_d;
  logic         udf_q, udf_d;
  logic         new_high_q, new_high_d;

  bcd_digit_t   add_eff, sub_eff, mag;
  bcd_op_e      op;
  logic         net_zero;
  logic [W-1:0] arith_sum;
  logic [DIGITS:0] chain;
  logic         score_gt;

  // Net amount as a sign (op) and magnitude; only digit 0 sees the magnitude.
  always_comb begin
    add_eff  = add_en ? clamp_digit(add_amt) : 4'd0;
    sub_eff  = sub_en ? clamp_digit(sub_amt) : 4'd0;
    net_zero = (add_eff == sub_eff);
    op       = (sub_eff > add_eff) ? OP_SUB : OP_ADD;
    mag      = (sub_eff > add_eff) ? (sub_eff - add_eff) : (add_eff - sub_eff);
  end

  assign chain[0] = 1'b0;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_t operand;
    if (k == 0) begin : g_lsd
      assign operand = mag;
    end else begin : g_upper
      assign operand = 4'd0;
    end

    bcd_digit_cell u_cell (
      .digit_i   (score_q[4*k +: 4]),
      .op_i      (op),
      .operand_i (operand),
      .cin_i     (chain[k]),
      .digit_o   (arith_sum[4*k +: 4]),
      .cout_o    (chain[k+1])
    );
  end

  always_comb begin
    score_d = score_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    if (pb_clear_op) begin
      for (int k = 0; k < DIGITS; k++) begin
        score_d[4*k +: 4] = clamp_digit(init_value[4*k +: 4]);
      end
    end else if (!net_zero) begin
      if (chain[DIGITS] && op == OP_ADD) begin
        ovf_d   = 1'b1;
        score_d = SATURATE ? ALL_NINES : arith_sum;
      end else if (chain[DIGITS]) begin
        udf_d   = 1'b1;
        score_d = '0;
      end else begin
        score_d = arith_sum;
      end
    end
  end

  // Most-significant differing digit decides the BCD magnitude comparison.
  always_comb begin
    logic decided;
    decided  = 1'b0;
    score_gt = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (!decided && (score_q[4*k +: 4] != high_q[4*k +: 4])) begin
        decided  = 1'b1;
        score_gt = (score_q[4*k +: 4] > high_q[4*k +: 4]);
      end
    end
    high_d     = score_gt ? score_q : high_q;
    new_high_d = score_gt;
  end

  // NOTE: registers use non-blocking '<=' so all state updates on an edge
  // read pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q    <= '0;
      high_q     <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      score_q    <= score_d;
      high_q     <= high_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      new_high_q <= new_high_d;
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign ovf        = ovf_q;
  assign udf        = udf_q;
  assign new_high   = new_high_q;

endmodule
